// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_bus_arbiter
// Purpose  : Shares one AHB address/data bus between MASTER_NUM masters.
//            Produces a registered one-hot grant, a registered owner index
//            (lagging the grant by one accepted transfer) and a combinational
//            master-lock flag. Holds the bus through fixed-length bursts and
//            locked sequences and parks it on master MASTER_NUM-1 when idle.
// Ports    : hclk      - bus clock, rising edge
//            hreset    - synchronous active-high reset
//            hbusreq   - per-master bus request   [MASTER_NUM-1:0]
//            hlock     - per-master lock request  [MASTER_NUM-1:0]
//            hready    - transfer done; every state change qualifies on it
//            htrans    - current owner's transfer type
//            hburst    - current owner's burst type
//            hgrant    - one-hot grant (registered) [MASTER_NUM-1:0]
//            hmaster   - address-phase owner index (registered) [3:0]
//            hmastlock - lock flag of the granted master (combinational)
// Options  : AHB_ARB_ROUND_ROBIN_EN - round-robin winner selection instead
//            of fixed priority (index 0 highest).
// Revision : 1.0 - initial release
// ============================================================================
module ahb_bus_arbiter #(
    parameter int MASTER_NUM = 4
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic [MASTER_NUM-1:0] hbusreq,
    input  logic [MASTER_NUM-1:0] hlock,
    input  logic                  hready,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hburst,
    output logic [MASTER_NUM-1:0] hgrant,
    output logic [3:0]            hmaster,
    output logic                  hmastlock
);

    localparam logic [1:0] c_ST_FREE   = 2'd0;
    localparam logic [1:0] c_ST_BURST  = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;

    localparam logic [1:0] c_TRANS_IDLE   = 2'd0;
    localparam logic [1:0] c_TRANS_NONSEQ = 2'd2;
    localparam logic [1:0] c_TRANS_SEQ    = 2'd3;

    localparam logic [3:0]            c_DEFAULT_IDX   = 4'(MASTER_NUM - 1);
    localparam logic [MASTER_NUM-1:0] c_DEFAULT_GRANT = {1'b1, {(MASTER_NUM-1){1'b0}}};
    localparam logic [MASTER_NUM-1:0] c_ONE           = {{(MASTER_NUM-1){1'b0}}, 1'b1};

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [MASTER_NUM-1:0] r_hgrant;
    logic [3:0]            r_hmaster;

    logic [1:0]            w_state_nxt;
    logic [3:0]            w_cnt_nxt;
    logic                  w_rearb;
    logic [3:0]            w_gidx;
    logic                  w_own_lock;
    logic                  w_any_req;
    logic [15:0]           w_req16;
    logic [3:0]            w_winner;
    logic [MASTER_NUM-1:0] w_winner_oh;

    // Widened request vector so a 4-bit index always selects cleanly;
    // bits at and above MASTER_NUM are tied to zero.
    assign w_req16   = 16'(hbusreq);
    assign w_any_req = |hbusreq;

    // One-hot grant to index.
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (r_hgrant[i]) begin
                w_gidx = w_gidx | 4'(i);
            end
        end
    end

    // Lock flag of whoever currently holds the grant.
    assign w_own_lock = |(hlock & r_hgrant);

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic [3:0] r_last_owner;
    logic [4:0] w_cand;

    // Search from last_owner+1 upward with wrap; walking the candidates in
    // reverse order lets the first one in search order win the last write.
    always_comb begin
        w_winner = c_DEFAULT_IDX;
        w_cand   = '0;
        for (int k = MASTER_NUM; k >= 1; k--) begin
            w_cand = 5'(r_last_owner) + 5'(k);
            if (w_cand >= 5'(MASTER_NUM)) begin
                w_cand = w_cand - 5'(MASTER_NUM);
            end
            if (w_req16[w_cand[3:0]]) begin
                w_winner = w_cand[3:0];
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_last_owner <= c_DEFAULT_IDX;
        end else if (hready && w_rearb && w_any_req) begin
            r_last_owner <= w_winner;
        end
    end
`else
    // Fixed priority: lowest requesting index wins, park on the default.
    always_comb begin
        w_winner = c_DEFAULT_IDX;
        for (int i = MASTER_NUM - 1; i >= 0; i--) begin
            if (w_req16[i]) begin
                w_winner = 4'(i);
            end
        end
    end
`endif

    assign w_winner_oh = c_ONE << w_winner;

    // Next-state logic; only consumed on hready cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rearb     = 1'b0;
        case (r_state)
            c_ST_FREE: begin
                if (w_own_lock) begin
                    // Lock wins over burst tracking; keep current owner.
                    w_state_nxt = c_ST_LOCKED;
                end else if (htrans == c_TRANS_NONSEQ && hburst >= 3'd2) begin
                    w_state_nxt = c_ST_BURST;
                    case (hburst[2:1])
                        2'b01:   w_cnt_nxt = 4'd3;
                        2'b10:   w_cnt_nxt = 4'd7;
                        default: w_cnt_nxt = 4'd15;
                    endcase
                end else begin
                    w_rearb = 1'b1;
                end
            end
            c_ST_BURST: begin
                if (w_own_lock) begin
                    w_state_nxt = c_ST_LOCKED;
                    w_cnt_nxt   = '0;
                end else if (htrans == c_TRANS_IDLE || htrans == c_TRANS_NONSEQ) begin
                    w_state_nxt = c_ST_FREE;
                    w_cnt_nxt   = '0;
                end else if (htrans == c_TRANS_SEQ) begin
                    if (r_cnt <= 4'd1) begin
                        // Final beat accepted: hand over immediately.
                        w_state_nxt = c_ST_FREE;
                        w_cnt_nxt   = '0;
                        w_rearb     = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
            end
            c_ST_LOCKED: begin
                // Leaving lock does not re-arbitrate on the same edge, which
                // covers the final locked data phase.
                if (!w_own_lock) begin
                    w_state_nxt = c_ST_FREE;
                end
            end
            default: begin
                w_state_nxt = c_ST_FREE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state   <= c_ST_FREE;
            r_cnt     <= '0;
            r_hgrant  <= c_DEFAULT_GRANT;
            r_hmaster <= c_DEFAULT_IDX;
        end else if (hready) begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hmaster <= w_gidx;
            if (w_rearb) begin
                r_hgrant <= w_winner_oh;
            end
        end
    end

    assign hgrant    = r_hgrant;
    assign hmaster   = r_hmaster;
    assign hmastlock = w_own_lock;

endmodule
`default_nettype wire

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

AHB bus arbiter sharing one AHB address/data bus between `MASTER_NUM` masters. Samples each master's `hbusreq`/`hlock`, drives a one-hot `hgrant` vector, the registered `hmaster` owner index and `hmastlock`. Holds the bus through fixed-length bursts and locked sequences, and parks the bus on the default master (index `MASTER_NUM-1`) when nobody requests. Sits between the master agents and the address/write-data muxes of the interconnect.

## Interface
- `MASTER_NUM`, default 4: number of masters, legal range 2..16; index 0 has highest priority, `MASTER_NUM-1` is the default master.
- `hclk` input 1: bus clock; all state updates on rising edge.
- `hreset` input 1: synchronous, active-high reset.
- `hbusreq` input `MASTER_NUM`: bus request per master.
- `hlock` input `MASTER_NUM`: lock request per master.
- `hready` input 1: slave-side transfer done; all handovers qualify on it.
- `htrans` input 2: current owner's transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- `hburst` input 3: current owner's burst type (SINGLE=0, INCR=1, WRAP4/INCR4=2/3, WRAP8/INCR8=4/5, WRAP16/INCR16=6/7).
- `hgrant` output `MASTER_NUM`: registered, always one-hot.
- `hmaster` output 4: registered index of the address-phase owner.
- `hmastlock` output 1: combinational, equals `hlock[idx(hgrant)]`.

## Operation
- FSM states: FREE, BURST, LOCKED. Reset state FREE.
- Winner selection: among set `hbusreq` bits, lowest index wins. If none set, the winner is `MASTER_NUM-1`.
- FREE: on `hready`=1 the winner is registered into `hgrant`. If `hready`=0, `hgrant` holds.
- FREE -> BURST: `hready`=1, `htrans`=NONSEQ, `hburst` ∈ {2..7}. Load the beat counter `cnt` with 3/7/15 for 4/8/16 beats.
- BURST:
  - `hready`=1 with `htrans`=SEQ decrements `cnt`.
  - BUSY and `hready`=0 hold `cnt`.
  - `htrans`=IDLE or NONSEQ terminates early and returns to FREE.
  - Arbitration is frozen while `cnt`>1. When `cnt`=1 and the SEQ beat is accepted, the winner is registered and the state returns to FREE. This lets the next owner take over right after the final beat.
  - INCR (1) and SINGLE never enter BURST.
- FREE/BURST -> LOCKED: `hready`=1 and `hlock[idx(hgrant)]`=1. Locking takes priority over burst tracking.
- LOCKED:
  - `hgrant` frozen regardless of other requests.
  - Exit to FREE on `hready`=1 with `hlock[idx(hgrant)]`=0. Arbitration resumes at the following `hready` cycle, giving one extra hold cycle for the final locked data phase.
- `hmaster`: on every `hready`=1 edge, `hmaster` <= `idx(hgrant)`. It lags `hgrant` by one accepted transfer.
- `hmastlock` is purely combinational from the current grant, with no register.
- Requests at indices ≥ `MASTER_NUM` do not exist. `hmaster` upper bits are zero when `MASTER_NUM` < 16.

## Timing
- Reset values:
  - `hgrant` = 1 << (`MASTER_NUM`-1), `hmaster` = `MASTER_NUM`-1, state FREE, `cnt` = 0.
  - `hmastlock` = `hlock[MASTER_NUM-1]`.
- Reset asserted mid-burst or mid-lock: the next edge forces the reset values and abandons `cnt` and the lock.
- Request to grant: 1 cycle when FREE and `hready`=1.
- Grant to `hmaster`: one further `hready`=1 edge.
- Simultaneous cases:
  - Requests arriving together: lowest index wins.
  - Owner raises `hlock` on the edge where a burst starts: enter LOCKED.
  - `hready`=0 stalls every state and counter.
- `hgrant` must never be all-zero or multi-hot, including the cycle after reset.

## Configuration
- `AHB_ARB_ROUND_ROBIN_EN`:
  - When defined, winner selection is round-robin. Search starts at `last_owner+1` and wraps at `MASTER_NUM-1` -> 0. `last_owner` updates whenever a new requesting master is granted and resets to `MASTER_NUM-1`.
  - When undefined, fixed priority applies (index 0 highest).
  - Default-master parking and the burst/lock holds are identical in both modes.

## Test plan
- Reset, no requests, `hready`=1 -> `hgrant`=4'b1000, `hmaster`=3, `hmastlock`=0 every cycle.
- Masters 1 and 2 request on the same cycle (fixed priority) -> next edge `hgrant`=4'b0010, following `hready` edge `hmaster`=1. Drop `hbusreq[1]` -> grant moves to master 2.
- Master 2 owns and issues INCR4 (NONSEQ + 3 SEQ) while master 0 requests -> `hgrant` stays 4'b0100 until the 3rd SEQ is accepted, then 4'b0001. With 2 inserted BUSY cycles -> handover delayed by exactly 2 cycles.
- Master 1 holds `hlock`=1 for 5 transfers while master 0 requests -> `hgrant` stays 4'b0010 and `hmastlock`=1. `hlock` drops -> one extra cycle, then grant to master 0.
- `hready`=0 for 3 cycles while master 0 requests -> `hgrant` and `hmaster` unchanged until `hready`=1. Reset pulse mid-INCR8 -> reset values on the next edge.
- With `AHB_ARB_ROUND_ROBIN_EN` and all 4 masters continuously requesting SINGLE transfers -> grant sequence 0,1,2,3,0.
